// File: rtl/sample_capture_if.sv
// Sample-capture port bundle: the ADC sample stream and trigger/arm controls
// going in, and the captured readout stream plus status coming back.
interface sample_capture_if #(
   parameter int DATA_W = 12
);
   logic [DATA_W-1:0] sample_in;
   logic              sample_valid;
   logic              trig;
   logic              arm;
   logic              rd_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              busy;
   logic              triggered;
   logic              done;

   // Producer/consumer side (ADC front end, trigger block, display)
   modport master (
      output sample_in, sample_valid, trig, arm, rd_ready,
      input  rd_valid, rd_data, rd_last, busy, triggered, done
   );

   // Capture engine side
   modport slave (
      input  sample_in, sample_valid, trig, arm, rd_ready,
      output rd_valid, rd_data, rd_last, busy, triggered, done
   );
endinterface

// File: rtl/sample_capture.sv
// Pre/post-trigger sample capture: a circular buffer keeps the last PRE_TRIG
// samples before a trigger, fills DEPTH-PRE_TRIG more after it, then streams
// the whole DEPTH-sample window out oldest-first over a valid/ready port.
module sample_capture #(
   parameter int DATA_W   = 12,
   parameter int DEPTH    = 512,
   parameter int PRE_TRIG = 128
) (
   input  logic            clk,
   input  logic            rst,
   sample_capture_if.slave bus
);
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;
   localparam int POST_N = DEPTH - PRE_TRIG;

   typedef enum logic [2:0] {IDLE, PRE_FILL, ARMED, POST, READOUT} state_t;

   state_t            state, nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;
   logic [AW-1:0]     wr_ptr, rd_addr, trig_addr, rd_start;
   logic [CW-1:0]     smp_cnt, rd_cnt;
   logic              trig_pend, trig_hit, wr_en;
   logic              rd_valid, rd_last, rd_issue, rd_xfer, rd_fin;
   logic              triggered, done;

   // Samples are only stored while acquiring; IDLE and READOUT drop them.
   assign wr_en    = bus.sample_valid &&
                     (state == PRE_FILL || state == ARMED || state == POST);
   // A trigger seen without a valid sample waits (trig_pend) for the next one.
   assign trig_hit = (state == ARMED) && bus.sample_valid && (bus.trig || trig_pend);
   assign rd_xfer  = rd_valid && bus.rd_ready;
   assign rd_fin   = rd_xfer && rd_last;
   // Fetch the next word whenever the output register is empty or draining.
   assign rd_issue = (state == READOUT) && (rd_cnt != CW'(DEPTH)) &&
                     (!rd_valid || bus.rd_ready);
   // When POST is skipped the trigger address is not latched yet, so bypass it.
   assign rd_start = (trig_hit ? wr_ptr : trig_addr) - AW'(PRE_TRIG);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (bus.arm) nxt = PRE_FILL;
         PRE_FILL: if (wr_en && smp_cnt == CW'(PRE_TRIG - 1)) nxt = ARMED;
         ARMED:    if (trig_hit) nxt = (POST_N == 1) ? READOUT : POST;
         POST:     if (wr_en && smp_cnt == CW'(POST_N - 1)) nxt = READOUT;
         READOUT:  if (rd_fin) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   // Write pointer, sample counter and trigger bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         smp_cnt   <= '0;
         trig_addr <= '0;
         trig_pend <= 1'b0;
         triggered <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         case (state)
            IDLE: begin
               if (bus.arm) begin
                  wr_ptr    <= '0;
                  smp_cnt   <= '0;
                  trig_pend <= 1'b0;
               end
            end
            PRE_FILL: begin
               // counter restarts so POST can count from the trigger sample
               if (wr_en) smp_cnt <= (nxt == ARMED) ? '0 : smp_cnt + 1'b1;
            end
            ARMED: begin
               if (trig_hit) begin
                  trig_addr <= wr_ptr;
                  triggered <= 1'b1;
                  trig_pend <= 1'b0;
                  smp_cnt   <= CW'(1);
               end else if (bus.trig) begin
                  trig_pend <= 1'b1;
               end
            end
            POST: begin
               if (wr_en) smp_cnt <= smp_cnt + 1'b1;
            end
            READOUT: begin
               if (rd_fin) triggered <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Sample buffer write port (contents survive reset)
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= bus.sample_in;
   end

   // Registered read port; holds its word while the consumer stalls
   always_ff @(posedge clk) begin
      if (rd_issue) ram_q <= mem[rd_addr];
   end

   // Readout address/count, output valid/last and completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr  <= '0;
         rd_cnt   <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= rd_fin;
         if (state != READOUT && nxt == READOUT) begin
            rd_addr <= rd_start;
            rd_cnt  <= '0;
         end else if (rd_issue) begin
            rd_addr  <= rd_addr + 1'b1;
            rd_cnt   <= rd_cnt + 1'b1;
            rd_valid <= 1'b1;
            rd_last  <= (rd_cnt == CW'(DEPTH - 1));
         end else if (rd_xfer) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end
      end
   end

   assign bus.rd_valid  = rd_valid;
   // Mask keeps rd_data at zero whenever nothing is being presented.
   assign bus.rd_data   = rd_valid ? ram_q : '0;
   assign bus.rd_last   = rd_last;
   assign bus.busy      = (state != IDLE);
   assign bus.triggered = triggered;
   assign bus.done      = done;
endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: directed and randomized acquisitions; a monitor
// keeps a window-level model of which samples must come out and checks them.
module tb_sample_capture;
   localparam int DW       = 12;
   localparam int DEPTH    = 16;
   localparam int PRE_TRIG = 4;
   localparam int POST_N   = DEPTH - PRE_TRIG;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sample_capture_if #(.DATA_W(DW)) bus ();

   sample_capture #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vec = 0;
   int err = 0;
   bit rnd_ready  = 0;
   bit hold_ready = 0;

   // model / scoreboard state
   int  m_st = 0;          // 0 idle, 1 acquiring, 2 reading out
   int  hist[$];
   int  exp_q[$];
   int  t_idx = -1;
   bit  pend = 0;
   bit  done_exp = 0;
   bit  stall_prev = 0;
   int  st_data = 0;
   bit  st_last = 0;
   bit  started = 0;
   int  lat = 0;
   int  xfers = 0;
   int  first_data = -1;
   int  last_data = -1;

   // Monitor: evaluated mid-cycle, describing what the next rising edge does.
   always @(negedge clk) begin
      int e;
      bit last_e;
      if (rst) begin
         m_st = 0; hist.delete(); exp_q.delete(); t_idx = -1; pend = 0;
         done_exp = 0; stall_prev = 0; started = 0; lat = 0;
      end else begin
         vec++;
         if (bus.done !== done_exp) begin
            err++; $display("FAIL done_pulse: got %0b want %0b", bus.done, done_exp);
         end
         done_exp = 0;
         if (stall_prev) begin
            vec++;
            if (bus.rd_valid !== 1'b1 || int'(bus.rd_data) !== st_data || bus.rd_last !== st_last) begin
               err++;
               $display("FAIL stall_hold: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                        bus.rd_valid, bus.rd_data, bus.rd_last, st_data, st_last);
            end
         end
         // acquisition: which samples land in the window
         if (m_st == 0) begin
            if (bus.arm) begin m_st = 1; hist.delete(); t_idx = -1; pend = 0; end
         end else if (m_st == 1) begin
            if (t_idx < 0 && bus.trig && hist.size() >= PRE_TRIG) pend = 1;
            if (bus.sample_valid) begin
               hist.push_back(int'(bus.sample_in));
               if (t_idx < 0 && pend) begin t_idx = hist.size() - 1; pend = 0; end
               if (t_idx >= 0 && hist.size() == t_idx + POST_N) begin
                  for (int k = t_idx - PRE_TRIG; k < t_idx + POST_N; k++) exp_q.push_back(hist[k]);
                  m_st = 2; started = 0; lat = 0;
               end
            end
         end else begin
            if (!started) begin
               if (bus.rd_valid) begin
                  started = 1; vec++;
                  if (lat > 2) begin
                     err++; $display("FAIL rd_latency: got %0d cycles want <=2", lat);
                  end
               end else lat++;
            end
         end
         // readout transfers
         if (bus.rd_valid && bus.rd_ready) begin
            vec++;
            if (m_st != 2 || exp_q.size() == 0) begin
               err++; $display("FAIL unexpected_xfer: got d=%0d want no transfer", bus.rd_data);
            end else begin
               if (exp_q.size() == DEPTH) first_data = int'(bus.rd_data);
               e = exp_q.pop_front();
               last_e = (exp_q.size() == 0);
               if (int'(bus.rd_data) !== e || bus.rd_last !== last_e) begin
                  err++;
                  $display("FAIL rd_word: got d=%0d l=%0b want d=%0d l=%0b",
                           bus.rd_data, bus.rd_last, e, last_e);
               end
               last_data = int'(bus.rd_data);
               xfers++;
               if (last_e) begin done_exp = 1; m_st = 0; end
            end
         end
         stall_prev = bus.rd_valid && !bus.rd_ready;
         st_data    = int'(bus.rd_data);
         st_last    = bus.rd_last;
      end
   end

   // One clock of stimulus; inputs change just after the rising edge.
   task automatic tick(input bit v, input int d, input bit t, input bit a);
      bus.sample_valid = v;
      bus.sample_in    = d[DW-1:0];
      bus.trig         = t;
      bus.arm          = a;
      bus.rd_ready     = rnd_ready ? (($urandom & 1) != 0) : !hold_ready;
      @(posedge clk); #1;
   endtask

   task automatic drain(input int max_cyc, output bit ok, output bit dn);
      ok = 0; dn = 0;
      for (int c = 0; c < max_cyc; c++) begin
         tick(0, 0, 0, 0);
         if (!bus.busy) begin ok = 1; dn = bus.done; break; end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      vec++;
      if ({bus.rd_valid, bus.rd_last, bus.busy, bus.triggered, bus.done, bus.rd_data} !== 17'd0) begin
         err++; $display("FAIL reset_outputs: got %h want 0",
            {bus.rd_valid, bus.rd_last, bus.busy, bus.triggered, bus.done, bus.rd_data});
      end
      rst = 1'b0;
      tick(0, 0, 0, 0);
      tick(1, 7, 1, 0);
      vec++;
      if (bus.busy !== 1'b0 || bus.triggered !== 1'b0) begin
         err++; $display("FAIL idle_after_reset: got busy=%0b trg=%0b want 0 0", bus.busy, bus.triggered);
      end
   endtask

   task automatic test_ramp;
      int b; bit ok, dn;
      b = xfers;
      tick(0, 0, 0, 1);
      for (int i = 0; i < 32; i++) tick(1, i, i == 20, 0);
      vec++;
      if (bus.busy !== 1'b1 || bus.triggered !== 1'b1) begin
         err++; $display("FAIL ramp_status: got busy=%0b trg=%0b want 1 1", bus.busy, bus.triggered);
      end
      drain(60, ok, dn);
      vec++;
      if (!ok || !dn) begin
         err++; $display("FAIL ramp_finish: got idle=%0b done=%0b want 1 1", ok, dn);
      end
      vec++;
      if (xfers - b != 16 || first_data != 16 || last_data != 31) begin
         err++; $display("FAIL ramp_window: got n=%0d first=%0d last=%0d want 16 16 31",
                         xfers - b, first_data, last_data);
      end
      tick(0, 0, 0, 0);
      vec++;
      if (bus.done !== 1'b0 || bus.triggered !== 1'b0) begin
         err++; $display("FAIL ramp_after: got done=%0b trg=%0b want 0 0", bus.done, bus.triggered);
      end
   endtask

   task automatic test_early_trig;
      int b; bit ok, dn;
      b = xfers;
      tick(0, 0, 0, 1);
      for (int i = 0; i <= 20; i++) begin
         tick(1, i, i == 2 || i == 9, 0);
         if (i == 2) begin
            vec++;
            if (bus.triggered !== 1'b0) begin
               err++; $display("FAIL early_ignored: got trg=%0b want 0", bus.triggered);
            end
         end
         if (i == 9) begin
            vec++;
            if (bus.triggered !== 1'b1) begin
               err++; $display("FAIL early_second: got trg=%0b want 1", bus.triggered);
            end
         end
      end
      drain(60, ok, dn);
      vec++;
      if (!ok || !dn || xfers - b != 16 || first_data != 5 || last_data != 20) begin
         err++; $display("FAIL early_window: got idle=%0b done=%0b n=%0d first=%0d last=%0d want 1 1 16 5 20",
                         ok, dn, xfers - b, first_data, last_data);
      end
   endtask

   task automatic test_gapped;
      int b; bit ok, dn;
      b = xfers;
      tick(0, 0, 0, 1);
      for (int i = 0; i < 40; i++) tick(1, i, 0, 0);
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);
      vec++;
      if (bus.triggered !== 1'b0) begin
         err++; $display("FAIL gap_pending: got trg=%0b want 0", bus.triggered);
      end
      tick(1, 40, 0, 0);
      vec++;
      if (bus.triggered !== 1'b1) begin
         err++; $display("FAIL gap_rise: got trg=%0b want 1", bus.triggered);
      end
      for (int i = 41; i <= 51; i++) tick(1, i, 0, 0);
      drain(60, ok, dn);
      vec++;
      if (!ok || !dn || xfers - b != 16 || first_data != 36 || last_data != 51) begin
         err++; $display("FAIL gap_window: got idle=%0b done=%0b n=%0d first=%0d last=%0d want 1 1 16 36 51",
                         ok, dn, xfers - b, first_data, last_data);
      end
   endtask

   task automatic test_backpressure;
      int b, nv, tgt; bit fired, fin, dn, v, t;
      rnd_ready = 1;
      for (int it = 0; it < 3; it++) begin
         b = xfers; nv = 0; fired = 0; fin = 0; dn = 0;
         tgt = PRE_TRIG + int'($urandom_range(20, 0));
         tick(0, 0, 0, 1);
         for (int c = 0; c < 400; c++) begin
            v = ($urandom % 4) != 0;
            t = !fired && nv >= tgt;
            tick(v, int'($urandom % 4096), t, 0);
            if (t) fired = 1;
            if (v) nv++;
            if (!bus.busy) begin fin = 1; dn = bus.done; break; end
         end
         vec++;
         if (!fin || !dn || xfers - b != 16) begin
            err++; $display("FAIL bp_run%0d: got idle=%0b done=%0b n=%0d want 1 1 16",
                            it, fin, dn, xfers - b);
         end
      end
      rnd_ready = 0;
   endtask

   task automatic test_reset_mid;
      int b; bit ok, dn;
      tick(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) tick(1, i, i == 6, 0);
      vec++;
      if (bus.busy !== 1'b1 || bus.triggered !== 1'b1) begin
         err++; $display("FAIL rmid_post: got busy=%0b trg=%0b want 1 1", bus.busy, bus.triggered);
      end
      rst = 1'b1; #1;
      vec++;
      if ({bus.rd_valid, bus.rd_last, bus.busy, bus.triggered, bus.done, bus.rd_data} !== 17'd0) begin
         err++; $display("FAIL rmid_post_rst: got %h want 0",
            {bus.rd_valid, bus.rd_last, bus.busy, bus.triggered, bus.done, bus.rd_data});
      end
      @(posedge clk); #1; rst = 1'b0;
      hold_ready = 1;
      tick(0, 0, 0, 1);
      for (int i = 0; i < 20; i++) tick(1, 100 + i, i == 8, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      vec++;
      if (bus.rd_valid !== 1'b1) begin
         err++; $display("FAIL rmid_readout: got rd_valid=%0b want 1", bus.rd_valid);
      end
      rst = 1'b1; #1;
      vec++;
      if ({bus.rd_valid, bus.rd_last, bus.busy, bus.triggered, bus.done, bus.rd_data} !== 17'd0) begin
         err++; $display("FAIL rmid_rd_rst: got %h want 0",
            {bus.rd_valid, bus.rd_last, bus.busy, bus.triggered, bus.done, bus.rd_data});
      end
      @(posedge clk); #1; rst = 1'b0;
      hold_ready = 0;
      b = xfers;
      tick(0, 0, 0, 1);
      for (int i = 0; i <= 16; i++) tick(1, 200 + i, i == 5, 0);
      drain(60, ok, dn);
      vec++;
      if (!ok || !dn || xfers - b != 16 || first_data != 201 || last_data != 216) begin
         err++; $display("FAIL rmid_recap: got idle=%0b done=%0b n=%0d first=%0d last=%0d want 1 1 16 201 216",
                         ok, dn, xfers - b, first_data, last_data);
      end
   endtask

   task automatic test_ignored;
      int b; bit fin, dn;
      b = xfers; fin = 0; dn = 0;
      hold_ready = 1;
      tick(0, 0, 0, 1);
      for (int i = 0; i <= 21; i++) tick(1, 50 + i, i == 10, 0);
      for (int k = 0; k < 5; k++) tick(1, 3000 + k, 1, 1);
      vec++;
      if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b1) begin
         err++; $display("FAIL ign_hold: got busy=%0b v=%0b want 1 1", bus.busy, bus.rd_valid);
      end
      hold_ready = 0;
      for (int c = 0; c < 60; c++) begin
         tick(1, 3100 + c, (c % 2) == 0, (c % 3) == 0);
         if (!bus.busy) begin fin = 1; dn = bus.done; break; end
      end
      vec++;
      if (!fin || !dn || xfers - b != 16 || first_data != 56 || last_data != 71) begin
         err++; $display("FAIL ign_window: got idle=%0b done=%0b n=%0d first=%0d last=%0d want 1 1 16 56 71",
                         fin, dn, xfers - b, first_data, last_data);
      end
      repeat (3) tick(0, 0, 0, 0);
      vec++;
      if (bus.busy !== 1'b0 || bus.triggered !== 1'b0) begin
         err++; $display("FAIL ign_no_restart: got busy=%0b trg=%0b want 0 0", bus.busy, bus.triggered);
      end
   endtask

   initial begin
      bus.sample_valid = 0; bus.sample_in = '0; bus.trig = 0; bus.arm = 0; bus.rd_ready = 1;
      test_reset();
      test_ramp();
      test_early_trig();
      test_gapped();
      test_backpressure();
      test_reset_mid();
      test_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter DATA_W, default 12, sample width in bits.
REQ-002 Parameter DEPTH, default 512, capture length in samples; power of two, >= 4.
REQ-003 Parameter PRE_TRIG, default 128, samples kept before the trigger sample; legal range 1..DEPTH-1.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sample_in  input  DATA_W  ADC sample.
REQ-007 sample_valid  input  1  sample_in valid this cycle.
REQ-008 trig  input  1  trigger event pulse from the trigger block.
REQ-009 arm  input  1  start-acquisition pulse.
REQ-010 rd_ready  input  1  downstream (display) accepts rd_data.
REQ-011 rd_valid  output  1  rd_data holds a captured sample.
REQ-012 rd_data  output  DATA_W  captured sample, oldest first.
REQ-013 rd_last  output  1  marks the final (DEPTH-th) readout sample.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 triggered  output  1  high from the trigger capture until return to IDLE.
REQ-016 done  output  1  one-cycle pulse after the last readout transfer.

Function
REQ-017 FSM states: IDLE, PRE_FILL, ARMED, POST, READOUT.
REQ-018 IDLE: on arm=1 -> clear write pointer and sample counter -> PRE_FILL; arm outside IDLE is ignored.
REQ-019 PRE_FILL: each sample_valid writes sample_in at the write pointer; the pointer increments modulo DEPTH.
REQ-020 PRE_FILL exits to ARMED on the cycle the PRE_TRIG-th sample is written; trig in PRE_FILL is ignored.
REQ-021 ARMED: samples keep being written circularly, overwriting the oldest.
REQ-022 ARMED, trig=1: the trigger sample is the sample written that cycle if sample_valid=1; otherwise it is the next valid sample.
REQ-023 On the trigger sample: latch trig_addr = write address, set triggered, -> POST.
REQ-024 POST: writes continue until DEPTH-PRE_TRIG samples are written, counting the trigger sample; then -> READOUT.
REQ-025 trig in POST or READOUT is ignored; sample_valid in IDLE or READOUT is dropped with no write.
REQ-026 READOUT start address = (trig_addr - PRE_TRIG) mod DEPTH; the address increments modulo DEPTH for DEPTH samples.
REQ-027 Readout handshake: a transfer occurs when rd_valid=1 and rd_ready=1.
REQ-028 rd_data and rd_last SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-029 rd_valid SHALL assert no later than 2 cycles after entering READOUT.
REQ-030 With rd_ready held high, one transfer SHALL occur per cycle (back-to-back).
REQ-031 rd_last=1 only with the DEPTH-th sample; after that transfer, rd_valid drops, done pulses for 1 cycle, triggered clears, and the FSM -> IDLE.
REQ-032 Wrap-around: a write or read pointer at DEPTH-1 advances to 0.
REQ-033 The memory is a single inferred block RAM, written only via the write pointer and read with 1-cycle registered latency.

Reset
REQ-034 rst=1 SHALL force IDLE immediately, from any state, including mid-capture or mid-readout.
REQ-035 Reset values: rd_valid=0, rd_last=0, busy=0, triggered=0, done=0, rd_data=0, pointers and counters=0.
REQ-036 Memory contents are not reset; a new acquisition requires a fresh arm.

Verification (bench with DATA_W=12, DEPTH=16, PRE_TRIG=4)
REQ-037 Ramp test: arm; feed samples 0,1,2,... every cycle; pulse trig with sample 20 -> readout 16,17,...,31 with rd_last on 31; done pulses once; busy falls.
REQ-038 Early trigger: pulse trig during PRE_FILL at sample 2, then again at sample 9 -> readout 5..20; trig at 2 has no effect.
REQ-039 Gapped trigger: trig pulse while sample_valid=0; next valid sample 40 -> readout begins 36, ends 51; triggered rises with sample 40.
REQ-040 Backpressure: rd_ready toggled randomly -> 16 transfers, no duplicates or drops, rd_data stable during stalls.
REQ-041 Reset mid-operation: rst asserted in POST and again in READOUT -> all outputs 0 the same cycle; a subsequent arm yields a correct full capture.
REQ-042 Ignored inputs: arm during READOUT and samples during READOUT -> readout data unchanged; no new acquisition starts.
